// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, fetch entry type and occupancy helper for the IF/ID buffer
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int IMM_W   = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc4;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_state_t;

    function automatic occ_state_t occ_of(input int unsigned count, input int unsigned depth);
        if (count == 0) begin
            return OCC_EMPTY;
        end
        if (count >= depth) begin
            return OCC_FULL;
        end
        return OCC_PARTIAL;
    endfunction

endpackage

// File: rtl/if_id_buffer_if.sv
// rtl/if_id_buffer_if.sv - fetch-side and decode-side handshake bundle of the IF/ID buffer
interface if_id_buffer_if
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) ();

    localparam int PTR_W = $clog2(DEPTH);

    logic               in_valid_i;
    logic               in_ready_o;
    logic [INSTR_W-1:0] in_instr_i;
    logic [PC_W-1:0]    in_pc4_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [INSTR_W-1:0] out_instr_o;
    logic [PC_W-1:0]    out_pc4_o;
    logic [IMM_W-1:0]   out_imm16_o;
    logic [PTR_W:0]     count_o;

    modport master (
        output in_valid_i, in_instr_i, in_pc4_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_instr_o, out_pc4_o, out_imm16_o, count_o
    );

    modport slave (
        input  in_valid_i, in_instr_i, in_pc4_i, out_ready_i,
        output in_ready_o, out_valid_o, out_instr_o, out_pc4_o, out_imm16_o, count_o
    );

endinterface

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - read/write pointers, occupancy count, push/pop qualification, flush and reset
module fifo_ptr_ctrl
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             i_push_req,
    input  logic             i_pop_req,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic             o_wr_en,
    output logic [PTR_W-1:0] o_wr_ptr,
    output logic [PTR_W-1:0] o_rd_ptr,
    output logic [CNT_W-1:0] o_count
);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    occ_state_t       w_occ;
    logic             w_push;
    logic             w_pop;

    always_comb begin
        w_occ = occ_of(32'(r_count), DEPTH);
    end

    // FULL refuses a push even when a pop frees a slot in the same cycle
    assign w_push = i_push_req & (w_occ != OCC_FULL);
    assign w_pop  = i_pop_req  & (w_occ != OCC_EMPTY);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_in_ready  = (w_occ != OCC_FULL);
    assign o_out_valid = (w_occ != OCC_EMPTY);
    assign o_wr_en     = w_push & ~flush_i & ~rst_i;
    assign o_wr_ptr    = r_wr_ptr;
    assign o_rd_ptr    = r_rd_ptr;
    assign o_count     = r_count;

endmodule

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - elastic IF/ID instruction buffer: storage, NOP gating and optional bypass
// IF_ID_BUF_BYPASS_EN adds a zero-latency in->out path when the buffer is empty and decode is ready.
module if_id_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    if_id_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    fetch_entry_t     w_head;
    fetch_entry_t     w_out;
    logic             w_bypass;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_wr_en;
    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;
    logic [PTR_W:0]   w_count;

`ifdef IF_ID_BUF_BYPASS_EN
    // A bypassed word goes straight to decode and never occupies a slot
    assign w_bypass = ~w_out_valid & bus.in_valid_i & bus.out_ready_i & ~flush_i;
`else
    assign w_bypass = 1'b0;
`endif

    fifo_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .i_push_req  (bus.in_valid_i & ~w_bypass),
        .i_pop_req   (bus.out_ready_i & ~w_bypass),
        .o_in_ready  (w_in_ready),
        .o_out_valid (w_out_valid),
        .o_wr_en     (w_wr_en),
        .o_wr_ptr    (w_wr_ptr),
        .o_rd_ptr    (w_rd_ptr),
        .o_count     (w_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_wr_ptr] <= {bus.in_instr_i, bus.in_pc4_i};
        end
    end

    assign w_head = r_mem[w_rd_ptr];

    always_comb begin
        w_out = {NOP_INSTR, {PC_W{1'b0}}};
        if (w_bypass) begin
            w_out = {bus.in_instr_i, bus.in_pc4_i};
        end else if (w_out_valid) begin
            w_out = w_head;
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = w_out_valid | w_bypass;
    assign bus.out_instr_o = w_out.instr;
    assign bus.out_pc4_o   = w_out.pc4;
    assign bus.out_imm16_o = w_out.instr[IMM_W-1:0];
    assign bus.count_o     = w_count;

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Elastic instruction buffer between the fetch stage (PC, instruction memory) and the decode stage (register file, decoder, sign extender).
- Holds up to DEPTH fetched instruction/PC+4 pairs with a valid/ready handshake, so a decode-side stall does not lose an in-flight fetch.
- Presents the head instruction, its PC+4, and the raw 16-bit immediate field that feeds the sign extender.
- Supports a synchronous flush for branch/jump redirect.

Parameters:
- DEPTH, 2, number of entries; power of two, 2..8.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  discard all entries (branch taken / jump).
- in_valid_i  in  1  fetch presents a valid instruction.
- in_ready_o  out  1  buffer accepts this cycle.
- in_instr_i  in  32  fetched instruction word.
- in_pc4_i  in  32  PC+4 of the fetched instruction.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  decode consumes head this cycle.
- out_instr_o  out  32  head instruction; 32'h0 (NOP) when out_valid_o=0.
- out_pc4_o  out  32  head PC+4; 32'h0 when out_valid_o=0.
- out_imm16_o  out  16  out_instr_o[15:0]; goes to the sign extender data input.
- count_o  out  PTR_W+1  number of occupied entries.

Behaviour:
- Storage: DEPTH x 64-bit array {instr, pc4}, plus wr_ptr, rd_ptr (PTR_W bits, wrap modulo DEPTH) and a count register.
- Occupancy states, derived from count:
  - EMPTY: count=0.
  - PARTIAL: 0<count<DEPTH.
  - FULL: count=DEPTH.
- Handshake:
  - push = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i.
  - in_ready_o = (count!=DEPTH); FULL refuses a push even if a pop occurs the same cycle.
  - out_valid_o = (count!=0).
  - Data must stay stable while valid and not accepted; in_* is sampled only on push.
- Latency: a pushed entry is visible at the outputs the cycle after the push edge (1 cycle).
- Outputs are a combinational read of mem[rd_ptr], gated to zero when EMPTY.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
- Ordering is strict FIFO; pointers wrap from DEPTH-1 to 0 with no bubble.
- Flush (flush_i=1): next cycle count=0, wr_ptr=rd_ptr=0. A push in the flush cycle is dropped. in_ready_o remains combinationally valid during flush. rst_i has priority over flush_i.
- Reset (rst_i=1 at an edge): count=0, pointers=0, every storage entry cleared to 0.
  - Outputs after reset: out_valid_o=0, in_ready_o=1, out_instr_o=0, out_pc4_o=0, out_imm16_o=0, count_o=0.
  - Reset mid-operation discards all entries, identical to flush.
- No overflow or underflow is possible. Push when FULL and pop when EMPTY are ignored by construction.

Optional Feature:
- Macro: IF_ID_BUF_BYPASS_EN.
- Defined (zero-latency pass-through):
  - Condition: count=0, in_valid_i=1, out_ready_i=1, flush_i=0.
  - out_valid_o=1 and out_instr_o/out_pc4_o/out_imm16_o come combinationally from in_*.
  - The entry is not written to storage; count stays 0.
  - If out_ready_i=0, the entry is stored normally.
- Undefined: the 1-cycle latency path only; no combinational in_* -> out_* path exists.

Decomposition:
- Shared package (cpu_pkg) holds:
  - INSTR_W=32, PC_W=32, IMM_W=16.
  - NOP_INSTR=32'h0000_0000.
  - A packed struct/typedef fetch_entry_t {instr, pc4}.
- One natural sub-module: fifo_ptr_ctrl, which owns the pointers, count, push/pop, flush and reset logic. The top module holds the storage array, output gating and the bypass mux.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles -> out_valid_o=0, in_ready_o=1, count_o=0, out_instr_o=0.
- Single push: in_instr_i=32'h2008_FFFF, in_pc4_i=32'h4 for one cycle, out_ready_i=0 -> next cycle out_valid_o=1, out_imm16_o=16'hFFFF, count_o=1; holds until out_ready_i=1.
- Fill and backpressure: push 0x11111111 and then 0x22222222 with out_ready_i=0 -> count_o=2, in_ready_o=0; a third offered word 0x33333333 is not accepted. Raise out_ready_i -> pops return 0x11111111 then 0x22222222.
- Simultaneous push/pop in PARTIAL: 5 consecutive cycles of push+pop -> count_o stays 1; pointers wrap; output order matches input order exactly.
- Flush: with count_o=2, assert flush_i together with in_valid_i (0x44444444) -> next cycle count_o=0, out_valid_o=0; 0x44444444 never appears at the output.
- Bypass (IF_ID_BUF_BYPASS_EN): EMPTY, in_valid_i=1, out_ready_i=1, in_instr_i=32'h8C01_0010 -> same cycle out_valid_o=1, out_imm16_o=16'h0010; count_o stays 0. Without the macro, the word appears one cycle later.
